// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bundle: condition inputs from the pipeline registers and
// the hold/clear/PC controls plus debug counters going back to them.
interface pipe_hazard_ctrl_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
);
    logic [REG_W-1:0] if_id_rs;
    logic [REG_W-1:0] if_id_rt;
    logic             if_id_uses_rt;
    logic             id_ex_mem_read;
    logic [REG_W-1:0] id_ex_rt;
    logic             ex_branch_taken;
    logic             ex_mem_read;
    logic             ex_mem_write;
    logic             dmem_ready;
    logic             pc_hold;
    logic             pc_load_branch;
    logic             if_id_hold;
    logic             if_id_clear;
    logic             id_ex_clear;
    logic             ex_mem_hold;
    logic             mem_wb_clear;
    logic             mem_error;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        input  if_id_rs, if_id_rt, if_id_uses_rt, id_ex_mem_read, id_ex_rt,
               ex_branch_taken, ex_mem_read, ex_mem_write, dmem_ready,
        output pc_hold, pc_load_branch, if_id_hold, if_id_clear, id_ex_clear,
               ex_mem_hold, mem_wb_clear, mem_error, stall_cnt, flush_cnt
    );

    modport slave (
        output if_id_rs, if_id_rt, if_id_uses_rt, id_ex_mem_read, id_ex_rt,
               ex_branch_taken, ex_mem_read, ex_mem_write, dmem_ready,
        input  pc_hold, pc_load_branch, if_id_hold, if_id_clear, id_ex_clear,
               ex_mem_hold, mem_wb_clear, mem_error, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, branch
// flushes and data-memory wait with timeout, plus saturating debug counters.
module pipe_hazard_ctrl #(
    parameter int REG_W   = 5,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic                clk,
    input  logic                clr_n,
    pipe_hazard_ctrl_if.master  hz,
    output logic [1:0]          fsm_state
);
    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {RUN, LU_STALL, MEM_WAIT, ERROR} state_t;

    state_t            state, state_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_nxt;
    logic              mem_error_q, err_set;
    logic [CNT_W-1:0]  stall_cnt_q, flush_cnt_q;
    logic              mem_busy, load_use;
    logic              hold_all, do_flush, do_bubble;

    assign mem_busy = (hz.ex_mem_read | hz.ex_mem_write) & ~hz.dmem_ready;
    assign load_use = hz.id_ex_mem_read && (hz.id_ex_rt != '0) &&
                      ((hz.id_ex_rt == hz.if_id_rs) ||
                       (hz.if_id_uses_rt && (hz.id_ex_rt == hz.if_id_rt)));

    always_comb begin
        state_nxt = state;
        wait_nxt  = wait_cnt;
        err_set   = 1'b0;
        hold_all  = 1'b0;
        do_flush  = 1'b0;
        do_bubble = 1'b0;
        case (state)
            RUN: begin
                if (mem_busy) begin
                    hold_all  = 1'b1;
                    state_nxt = MEM_WAIT;
                    wait_nxt  = WAIT_W'(1);
                end else if (hz.ex_branch_taken) begin
                    do_flush = 1'b1;
                end else if (load_use) begin
                    do_bubble = 1'b1;
                    state_nxt = LU_STALL;
                end
            end
            // The bubble already removed the dependency, so load_use is not rechecked.
            LU_STALL: begin
                if (mem_busy) begin
                    hold_all  = 1'b1;
                    state_nxt = MEM_WAIT;
                    wait_nxt  = WAIT_W'(1);
                end else begin
                    state_nxt = RUN;
                end
            end
            MEM_WAIT: begin
                if (mem_busy) begin
                    hold_all = 1'b1;
                    if (wait_cnt >= WAIT_W'(TIMEOUT - 1)) begin
                        state_nxt = ERROR;
                        err_set   = 1'b1;
                    end else begin
                        wait_nxt = wait_cnt + WAIT_W'(1);
                    end
                end else begin
                    state_nxt = RUN;
                    wait_nxt  = '0;
                end
            end
            ERROR: begin
                hold_all = 1'b1;
            end
            default: state_nxt = RUN;
        endcase
    end

    // Controls are forced low while reset is asserted.
    assign hz.pc_hold        = clr_n & (hold_all | do_bubble);
    assign hz.if_id_hold     = clr_n & (hold_all | do_bubble);
    assign hz.ex_mem_hold    = clr_n & hold_all;
    assign hz.mem_wb_clear   = clr_n & hold_all;
    assign hz.pc_load_branch = clr_n & do_flush;
    assign hz.if_id_clear    = clr_n & do_flush;
    assign hz.id_ex_clear    = clr_n & (do_flush | do_bubble);
    assign hz.mem_error      = mem_error_q;
    assign hz.stall_cnt      = stall_cnt_q;
    assign hz.flush_cnt      = flush_cnt_q;
    assign fsm_state         = state;

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state       <= RUN;
            wait_cnt    <= '0;
            mem_error_q <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            if (err_set)
                mem_error_q <= 1'b1;
            if ((hold_all || do_bubble) && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (do_flush && (flush_cnt_q != '1))
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush controller for the 5-stage pipeline (IF, ID, EX, MEM, WB). It drives the hold/clear inputs of the IF_ID, ID_EX and EX_MEM/MEM_WB reg_pipe instances and the PC hold. It detects three conditions and sequences the stages around each: load-use hazards, taken branches, and a data memory that is not ready. It also keeps saturating stall and flush counters for debug.

Parameters:
REG_W, 5, register address width
TIMEOUT, 64, max consecutive MEM_WAIT cycles before error
CNT_W, 16, width of performance counters

Ports:
clk  in  1  pipeline clock, all state on rising edge
clr_n  in  1  synchronous active-low reset
if_id_rs  in  REG_W  rs field of instruction in IF/ID
if_id_rt  in  REG_W  rt field of instruction in IF/ID
if_id_uses_rt  in  1  IF/ID instruction reads rt (R-type/store/branch)
id_ex_mem_read  in  1  mem_read control in ID/EX
id_ex_rt  in  REG_W  load destination in ID/EX
ex_branch_taken  in  1  branch resolved taken in EX
ex_mem_read  in  1  mem_read control in EX/MEM
ex_mem_write  in  1  mem_write control in EX/MEM
dmem_ready  in  1  data memory completes access this cycle
pc_hold  out  1  PC keeps value
pc_load_branch  out  1  PC takes branch target
if_id_hold  out  1  IF_ID hold
if_id_clear  out  1  IF_ID clear (flush)
id_ex_clear  out  1  ID_EX reg+control clear (bubble)
ex_mem_hold  out  1  EX_MEM hold
mem_wb_clear  out  1  MEM_WB clear (bubble into WB)
mem_error  out  1  sticky memory timeout flag
stall_cnt  out  CNT_W  saturating count of stall cycles
flush_cnt  out  CNT_W  saturating count of branch flushes

Behaviour:
- Registered state: fsm, wait_cnt, mem_error, stall_cnt, flush_cnt. Control outputs are combinational from the FSM state and the inputs, so they take effect in the same cycle.
- Reset (clr_n=0 at posedge): fsm=RUN, wait_cnt=0, mem_error=0, counters=0. While clr_n=0, all control outputs are 0.
- Condition terms:
  - mem_busy = (ex_mem_read | ex_mem_write) & ~dmem_ready
  - load_use = id_ex_mem_read & (id_ex_rt != 0) & ((id_ex_rt == if_id_rs) | (if_id_uses_rt & id_ex_rt == if_id_rt))
- Priority: ERROR > mem_busy > ex_branch_taken > load_use.
- State RUN:
  - mem_busy: pc_hold = if_id_hold = ex_mem_hold = mem_wb_clear = 1, id_ex_clear = 0 (EX result frozen by the EX_MEM hold). Go to MEM_WAIT with wait_cnt=1.
  - else ex_branch_taken: pc_load_branch = if_id_clear = id_ex_clear = 1. flush_cnt++. Stay RUN.
  - else load_use: pc_hold = if_id_hold = id_ex_clear = 1. Go to LU_STALL.
  - else: all outputs 0.
- State LU_STALL: exactly one cycle.
  - Outputs all 0, unless mem_busy, which gets the same outputs as in RUN and goes to MEM_WAIT.
  - Otherwise return to RUN. load_use is not re-evaluated in this cycle, because the bubble already cleared it.
- State MEM_WAIT:
  - mem_busy still true: same outputs as mem_busy in RUN; wait_cnt++.
  - wait_cnt reaching TIMEOUT: go to ERROR and set mem_error.
  - dmem_ready=1: outputs 0, wait_cnt=0, return to RUN.
  - A taken branch seen while in MEM_WAIT is handled in the first RUN cycle after exit; EX is frozen, so ex_branch_taken stays valid.
- State ERROR: pc_hold = if_id_hold = ex_mem_hold = mem_wb_clear = 1, mem_error=1. Exits only via reset.
- stall_cnt increments on every cycle where pc_hold=1, including ERROR. stall_cnt and flush_cnt saturate at all-ones and never wrap.
- Never drives if_id_hold and if_id_clear together. When both a flush and a hold would apply, the flush is dropped because mem_busy has priority.
- Register 0 as load destination never stalls.
- Reset mid-MEM_WAIT or mid-ERROR returns to RUN on the next edge with all outputs 0.

Test Plan:
1. Load-use: lw $2 in ID/EX (id_ex_mem_read=1, id_ex_rt=2), add using if_id_rs=2 -> one cycle with pc_hold=if_id_hold=id_ex_clear=1, next cycle all 0; stall_cnt=1.
2. No hazard on $0: id_ex_rt=0, if_id_rs=0, id_ex_mem_read=1 -> no stall, stall_cnt=0.
3. Branch: ex_branch_taken=1 for one cycle -> pc_load_branch=if_id_clear=id_ex_clear=1 that cycle; flush_cnt=1. Simultaneous load_use is ignored.
4. Memory wait: ex_mem_read=1, dmem_ready=0 for 3 cycles then 1 -> holds and mem_wb_clear asserted 3 cycles, released on the ready cycle; stall_cnt=3. A branch asserted during the wait yields a flush in the first RUN cycle.
5. Timeout: TIMEOUT=4, dmem_ready held 0 -> mem_error=1 after 4 cycles, holds stay asserted; clr_n=0 for one edge -> mem_error=0, outputs 0.
6. Saturation: CNT_W=4, force 20 stall cycles -> stall_cnt=15 and remains 15.
